// File: rtl/game_ctrl_pkg.sv
// Shared game_ctrl definitions: game_state encodings and timing constants,
// also used by the LCD controller.
package game_ctrl_pkg;

  typedef enum logic [1:0] {
    S_MAIN     = 2'b00,
    S_CONTINUE = 2'b01,
    S_OVER     = 2'b10,
    S_CLEAR    = 2'b11
  } game_state_e;

  localparam int unsigned CYC_PER_SEC = 1000;

endpackage

// File: rtl/game_ctrl_if.sv
// Player/field signals between game_ctrl and its surroundings (buttons, block
// generator, collision logic, LCD controller).
interface game_ctrl_if;
  import game_ctrl_pkg::*;

  logic        btn_start;
  logic        hit;
  logic        block_pass;
  game_state_e game_state;
  logic [3:0]  block_remain;
  logic        spawn_tick;
  logic        play_active;

  modport master (
    output btn_start, hit, block_pass,
    input  game_state, block_remain, spawn_tick, play_active
  );

  modport slave (
    input  btn_start, hit, block_pass,
    output game_state, block_remain, spawn_tick, play_active
  );

endinterface

// File: rtl/btn_debounce.sv
// Start-button conditioning: 2-FF synchronizer, debouncer and rising-edge
// press detector.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            armed_q, armed_d;
  logic            press_q, press_d;
  logic [CntW-1:0] chg_cnt_q, chg_cnt_d;
  logic [CntW-1:0] low_cnt_q, low_cnt_d;

  always_comb begin
    level_d   = level_q;
    chg_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (chg_cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
        level_d = sync2_q;
      end else begin
        chg_cnt_d = chg_cnt_q + 1'b1;
      end
    end

    // A button held through reset must be seen released before it may start a game.
    armed_d   = armed_q;
    low_cnt_d = '0;
    if (!sync2_q && !armed_q) begin
      if (low_cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
        armed_d = 1'b1;
      end else begin
        low_cnt_d = low_cnt_q + 1'b1;
      end
    end

    press_d = armed_q & level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      armed_q   <= 1'b0;
      press_q   <= 1'b0;
      chg_cnt_q <= '0;
      low_cnt_q <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      armed_q   <= armed_d;
      press_q   <= press_d;
      chg_cnt_q <= chg_cnt_d;
      low_cnt_q <= low_cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/game_ctrl.sv
// Game flow controller: MAIN -> CONTINUE -> OVER/CLEAR -> MAIN, block counting
// and spawn pacing. Define GAME_TIMEOUT_EN to add the play-time limit.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS   = 9,
  parameter int unsigned DEBOUNCE_CYC = 20,
  parameter int unsigned SPAWN_CYC    = 1500,
  parameter int unsigned TIME_LIMIT_S = 30
) (
  input logic        clk,
  input logic        rst,
  game_ctrl_if.slave bus
);

  localparam int unsigned SpawnW = $clog2(SPAWN_CYC + 1);

  logic              press;
  logic              timeout;
  game_state_e       state_q, state_d;
  logic [3:0]        remain_q, remain_d;
  logic [SpawnW-1:0] spawn_cnt_q, spawn_cnt_d;
  logic              spawn_q, spawn_d;
  logic              play_q, play_d;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn_debounce (
    .clk  (clk),
    .rst  (rst),
    .raw  (bus.btn_start),
    .press(press)
  );

`ifdef GAME_TIMEOUT_EN
  localparam int unsigned MsW  = $clog2(CYC_PER_SEC + 1);
  localparam int unsigned SecW = $clog2(TIME_LIMIT_S + 1);

  logic [MsW-1:0]  ms_cnt_q, ms_cnt_d;
  logic [SecW-1:0] sec_cnt_q, sec_cnt_d;

  assign timeout = (ms_cnt_q == MsW'(CYC_PER_SEC - 1)) &&
                   (sec_cnt_q == SecW'(TIME_LIMIT_S - 1));

  always_comb begin
    ms_cnt_d  = ms_cnt_q;
    sec_cnt_d = sec_cnt_q;
    if (state_q == S_MAIN && press) begin
      ms_cnt_d  = '0;
      sec_cnt_d = '0;
    end else if (state_q == S_CONTINUE) begin
      if (ms_cnt_q == MsW'(CYC_PER_SEC - 1)) begin
        ms_cnt_d  = '0;
        sec_cnt_d = sec_cnt_q + 1'b1;
      end else begin
        ms_cnt_d = ms_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ms_cnt_q  <= '0;
      sec_cnt_q <= '0;
    end else begin
      ms_cnt_q  <= ms_cnt_d;
      sec_cnt_q <= sec_cnt_d;
    end
  end
`else
  logic unused_time_cfg;
  assign unused_time_cfg = (TIME_LIMIT_S != 0) ^ (CYC_PER_SEC != 0);
  assign timeout         = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    spawn_cnt_d = spawn_cnt_q;
    spawn_d     = 1'b0;

    unique case (state_q)
      S_MAIN: begin
        if (press) begin
          state_d     = S_CONTINUE;
          remain_d    = 4'(NUM_BLOCKS);
          spawn_cnt_d = '0;
        end
      end
      S_CONTINUE: begin
        if (bus.hit || timeout) begin
          state_d = S_OVER;
        end else if (bus.block_pass && remain_q != 4'd0) begin
          remain_d = remain_q - 4'd1;
          if (remain_q == 4'd1) begin
            state_d = S_CLEAR;
          end
        end
        // No spawn on the edge that leaves CONTINUE.
        if (state_d == S_CONTINUE) begin
          if (spawn_cnt_q == SpawnW'(SPAWN_CYC - 1)) begin
            spawn_cnt_d = '0;
            spawn_d     = 1'b1;
          end else begin
            spawn_cnt_d = spawn_cnt_q + 1'b1;
          end
        end
      end
      S_OVER, S_CLEAR: begin
        if (press) begin
          state_d = S_MAIN;
        end
      end
    endcase

    play_d = (state_d == S_CONTINUE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_MAIN;
      remain_q    <= 4'd0;
      spawn_cnt_q <= '0;
      spawn_q     <= 1'b0;
      play_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      spawn_cnt_q <= spawn_cnt_d;
      spawn_q     <= spawn_d;
      play_q      <= play_d;
    end
  end

  assign bus.game_state   = state_q;
  assign bus.block_remain = remain_q;
  assign bus.spawn_tick   = spawn_q;
  assign bus.play_active  = play_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: vector table, hand-written corner sequences
// and randomized play against a cycle-level game model.
module tb_game_ctrl;
  import game_ctrl_pkg::*;

  localparam int unsigned NB = 9;
  localparam int unsigned DB = 20;
  localparam int unsigned SP = 1500;
  localparam int unsigned TL = 2;

  typedef struct {
    logic        hit;
    logic        pass;
    game_state_e st;
    int          rem;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_ctrl_if bus();

  game_ctrl #(
    .NUM_BLOCKS  (NB),
    .DEBOUNCE_CYC(DB),
    .SPAWN_CYC   (SP),
    .TIME_LIMIT_S(TL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  int   starts = 0;
  logic pa_prev = 1'b0;

  // Counts game starts as rising edges of play_active.
  always @(negedge clk) begin
    if (bus.play_active && !pa_prev) starts <= starts + 1;
    pa_prev <= bus.play_active;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input string name, input game_state_e exp, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.game_state == exp) break;
      @(negedge clk);
    end
    chk(name, int'(bus.game_state), int'(exp));
  endtask

  // Clean press: released long enough to re-arm, then held until the state moves.
  task automatic press(input string name, input game_state_e exp);
    bus.btn_start = 1'b0;
    cyc(2 * DB + 10);
    bus.btn_start = 1'b1;
    @(negedge clk);
    wait_state(name, exp, 200);
    bus.btn_start = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input game_state_e st, input int rem,
                               input int spawn);
    chk({tag, "_state"}, int'(bus.game_state), int'(st));
    chk({tag, "_remain"}, int'(bus.block_remain), rem);
    chk({tag, "_spawn"}, int'(bus.spawn_tick), spawn);
    chk({tag, "_play"}, int'(bus.play_active), int'(st == S_CONTINUE));
  endtask

  vec_t tbl [11];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    game_state_e m_st;
    int          m_rem;
    int          elapsed;
    int          spawns;
    int          s0;
    logic        h, p;

    for (int i = 0; i < 9; i++) begin
      tbl[i] = '{hit: 1'b0, pass: 1'b1, st: (i == 8) ? S_CLEAR : S_CONTINUE, rem: 8 - i};
    end
    tbl[9]  = '{hit: 1'b0, pass: 1'b1, st: S_CLEAR, rem: 0};
    tbl[10] = '{hit: 1'b1, pass: 1'b0, st: S_CLEAR, rem: 0};

    bus.btn_start  = 1'b0;
    bus.hit        = 1'b0;
    bus.block_pass = 1'b0;
    rst            = 1'b1;
    cyc(3);
    check_outputs("reset", S_MAIN, 0, 0);
    rst = 1'b0;

    // Bouncy start: 5 bounces in 10 cycles, then held high.
    cyc(2 * DB + 10);
    s0 = starts;
    for (int i = 0; i < 10; i++) begin
      bus.btn_start = (i % 2 == 0);
      cyc(1);
    end
    bus.btn_start = 1'b1;
    cyc(50);
    check_outputs("bounce", S_CONTINUE, NB, 0);
    cyc(100);
    chk("bounce_one_start", starts - s0, 1);
    bus.btn_start = 1'b0;

    // Passes 100 cycles apart down to CLEAR; extra inputs in CLEAR ignored.
    for (int i = 0; i < 11; i++) begin
      bus.hit        = tbl[i].hit;
      bus.block_pass = tbl[i].pass;
      cyc(1);
      bus.hit        = 1'b0;
      bus.block_pass = 1'b0;
      check_outputs($sformatf("tbl%0d", i), tbl[i].st, tbl[i].rem, 0);
      cyc(99);
    end
    press("clear_to_main", S_MAIN);
    chk("clear_to_main_remain", int'(bus.block_remain), 0);

    // Spawn pacing and play time limit, counted from the entry edge.
    press("spawn_start", S_CONTINUE);
    chk("spawn_start_remain", int'(bus.block_remain), NB);
    spawns = 0;
    for (int k = 1; k <= 5000; k++) begin
      cyc(1);
      if (bus.spawn_tick) spawns++;
`ifdef GAME_TIMEOUT_EN
      if (k == TL * CYC_PER_SEC - 1) chk("timeout_before", int'(bus.game_state), S_CONTINUE);
      if (k == TL * CYC_PER_SEC) begin
        chk("timeout_over", int'(bus.game_state), S_OVER);
        chk("timeout_spawn", int'(bus.spawn_tick), 0);
        break;
      end
`endif
      chk($sformatf("spawn_k%0d", k), int'(bus.spawn_tick), int'(k % SP == 0));
    end
`ifdef GAME_TIMEOUT_EN
    chk("spawn_count", spawns, 1);
    press("timeout_to_main", S_MAIN);
    press("restart", S_CONTINUE);
`else
    chk("spawn_count", spawns, 3);
    chk("no_timeout_5000", int'(bus.game_state), S_CONTINUE);
`endif

    // Hit and pass together at block_remain 4.
    for (int i = 0; i < 5; i++) begin
      bus.block_pass = 1'b1;
      cyc(1);
      bus.block_pass = 1'b0;
      cyc(1);
    end
    chk("pre_hit_remain", int'(bus.block_remain), 4);
    bus.hit        = 1'b1;
    bus.block_pass = 1'b1;
    cyc(1);
    bus.hit        = 1'b0;
    bus.block_pass = 1'b0;
    check_outputs("hit_pass", S_OVER, 4, 0);
    cyc(1);
    chk("hit_pass_spawn_after", int'(bus.spawn_tick), 0);
    press("over_to_main", S_MAIN);
    chk("over_to_main_remain", int'(bus.block_remain), 4);

    // Randomized games with the button held (press ignored while playing).
    for (int g = 0; g < 3; g++) begin
      if (bus.game_state != S_MAIN) press($sformatf("rnd%0d_main", g), S_MAIN);
      press($sformatf("rnd%0d_start", g), S_CONTINUE);
      bus.btn_start = 1'b1;
      m_st    = S_CONTINUE;
      m_rem   = NB;
      elapsed = 0;
      for (int i = 0; i < 1300; i++) begin
        h = (i > 40 && $urandom_range(0, 199) == 0) || (i == 1199);
        p = ($urandom_range(0, 7) == 0);
        bus.hit        = h;
        bus.block_pass = p;
        if (m_st == S_CONTINUE) begin
          elapsed++;
`ifdef GAME_TIMEOUT_EN
          if (elapsed == TL * CYC_PER_SEC) h = 1'b1;
`endif
          if (h) begin
            m_st = S_OVER;
          end else if (p) begin
            m_rem--;
            if (m_rem == 0) m_st = S_CLEAR;
          end
        end
        cyc(1);
        check_outputs($sformatf("rnd%0d_c%0d", g, i), m_st, m_rem,
                      int'(m_st == S_CONTINUE && elapsed % SP == 0));
        if (m_st != S_CONTINUE && i > 1200) break;
      end
      bus.hit        = 1'b0;
      bus.block_pass = 1'b0;
    end

    // Reset mid-game with the button held: no restart until a fresh press.
    press("rst_main", S_MAIN);
    press("rst_start", S_CONTINUE);
    bus.btn_start = 1'b1;
    cyc(100);
    #2 rst = 1'b1;
    #1;
    check_outputs("rst_async", S_MAIN, 0, 0);
    cyc(2);
    rst = 1'b0;
    s0  = starts;
    cyc(200);
    chk("rst_held_state", int'(bus.game_state), S_MAIN);
    chk("rst_held_starts", starts - s0, 0);
    press("rst_fresh_press", S_CONTINUE);
    chk("rst_fresh_remain", int'(bus.block_remain), NB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 9: blocks to clear per game, legal range 1..15.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 20: clk cycles btn_start must be stable before a level change is accepted.
REQ-003 SHALL have parameter SPAWN_CYC, default 1500: clk cycles between spawn_tick pulses.
REQ-004 SHALL have parameter TIME_LIMIT_S, default 30: play time limit in seconds (used only with the macro in REQ-026).
REQ-005 SHALL have port clk, input, 1: 1 kHz system clock.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port btn_start, input, 1: raw push-button level, asynchronous to clk, active-high.
REQ-008 SHALL have port hit, input, 1: 1-cycle pulse, player collided with a block.
REQ-009 SHALL have port block_pass, input, 1: 1-cycle pulse, one block left the field without collision.
REQ-010 SHALL have port game_state, output, 2: 00 MAIN, 01 CONTINUE, 10 OVER, 11 CLEAR; drives the LCD controller.
REQ-011 SHALL have port block_remain, output, 4: unsigned blocks still to pass; drives the LCD controller.
REQ-012 SHALL have port spawn_tick, output, 1: 1-cycle pulse requesting the block generator to create a block.
REQ-013 SHALL have port play_active, output, 1: high exactly while game_state is CONTINUE.

Function
REQ-014 SHALL pass btn_start through a 2-FF synchronizer and then a debouncer; the debounced level changes only after DEBOUNCE_CYC consecutive equal synchronized samples.
REQ-015 SHALL generate a 1-cycle press event on each 0->1 transition of the debounced level; holding the button yields exactly one event.
REQ-016 SHALL, in MAIN, on press: go to CONTINUE, load block_remain with NUM_BLOCKS, and clear the spawn and second counters, all in the same edge.
REQ-017 SHALL, in CONTINUE, on hit: go to OVER with block_remain held.
REQ-018 SHALL, in CONTINUE, on block_pass without hit: decrement block_remain; if block_remain was 1, go to CLEAR with block_remain 0.
REQ-019 SHALL give hit priority over block_pass in the same cycle: go to OVER, no decrement.
REQ-020 SHALL never decrement block_remain below 0, and SHALL ignore hit and block_pass outside CONTINUE.
REQ-021 SHALL, in OVER or CLEAR, on press: go to MAIN with block_remain held; no other input leaves OVER or CLEAR.
REQ-022 SHALL ignore press events in CONTINUE.
REQ-023 SHALL, in CONTINUE, assert spawn_tick for one cycle when the spawn counter reaches SPAWN_CYC-1 and then wrap it to 0; the first pulse occurs SPAWN_CYC cycles after entering CONTINUE.
REQ-024 SHALL hold spawn_tick low outside CONTINUE, including the cycle of the transition out of CONTINUE.
REQ-025 SHALL register all outputs, so state changes are visible on the clk edge after the triggering input cycle.

Configuration
REQ-026 SHALL, with GAME_TIMEOUT_EN defined, count elapsed seconds in CONTINUE (1000 clk cycles per second) and go to OVER when the count reaches TIME_LIMIT_S, with hit or timeout taking priority over block_pass in the same cycle.
REQ-027 SHALL, without GAME_TIMEOUT_EN, contain no second counter, with CONTINUE left only via hit or CLEAR.

Reset
REQ-028 SHALL, on rst asserted (including mid-game), immediately force game_state MAIN, block_remain 0, spawn_tick 0, play_active 0, and clear all counters and the debouncer and synchronizer to 0.
REQ-029 SHALL require a fresh press, seen as a debounced 0->1 after reset release, to leave MAIN; a button held through reset SHALL NOT start a game.

Structure
REQ-030 SHALL place the game_state encodings (S_MAIN, S_CONTINUE, S_OVER, S_CLEAR) in a shared package used by game_ctrl and the LCD controller.
REQ-031 SHALL place the 1000-cycles-per-second constant in the same shared package.
REQ-032 SHALL implement the synchronizer, debouncer and edge detector as one sub-module, btn_debounce (in: clk, rst, raw; out: press pulse).

Verification
REQ-033 SHALL verify: btn_start bounces 5 times in 10 cycles, then stays high 50 cycles -> exactly one start; MAIN->CONTINUE and block_remain=9.
REQ-034 SHALL verify: in CONTINUE, 9 block_pass pulses 100 cycles apart -> block_remain 8..1, then CLEAR with block_remain 0.
REQ-035 SHALL verify: block_remain=4, hit and block_pass in the same cycle -> OVER, block_remain stays 4, spawn_tick stays low.
REQ-036 SHALL verify: 4600 cycles in CONTINUE with no events -> spawn_tick pulses at cycles 1500, 3000 and 4500 after entry.
REQ-037 SHALL verify: with GAME_TIMEOUT_EN and TIME_LIMIT_S=2 -> OVER exactly 2000 cycles after entry; without the macro -> still CONTINUE at 5000 cycles.
REQ-038 SHALL verify: rst pulsed mid-CONTINUE with btn_start held high -> MAIN and block_remain 0 immediately, no restart until button released and pressed again.
